line_clear_ctrl: RTL

LINE_CLEAR_CTRL -- requirements
Module: line_clear_ctrl

---
 rtl/line_clear_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/line_clear_ctrl.sv
// Line-clear controller: scans the 20-row grid bottom-up, compacts non-full rows
// downward, zero-fills the vacated top rows and accumulates a saturating score.
module line_clear_ctrl (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic        new_game,
  output logic [4:0]  row_raddr,
  input  logic [29:0] row_rdata,
  output logic [4:0]  row_waddr,
  output logic [29:0] row_wdata,
  output logic        row_we,
  output logic        busy,
  output logic        done,
  output logic [4:0]  lines_cleared,
  output logic [9:0]  score
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FILL,
    DONE
  } state_t;

  localparam logic [4:0] LAST_ROW  = 5'd19;
  localparam logic [9:0] SCORE_MAX = 10'd1023;

  state_t      state_q, state_d;
  logic [4:0]  rd_q, rd_d;
  logic [4:0]  wr_q, wr_d;
  logic [4:0]  count_q, count_d;
  logic [4:0]  lines_q, lines_d;
  logic [9:0]  score_q, score_d;

  logic        row_full;
  logic [3:0]  points;
  logic [10:0] score_sum;

  always_comb begin
    row_full = 1'b1;
    for (int unsigned c = 0; c < 10; c++) begin
      if (row_rdata[3*c +: 3] == 3'd0) row_full = 1'b0;
    end
  end

  always_comb begin
    case (count_q)
      5'd0:    points = 4'd0;
      5'd1:    points = 4'd1;
      5'd2:    points = 4'd3;
      5'd3:    points = 4'd5;
      default: points = 4'd8;
    endcase
  end

  assign score_sum = {1'b0, score_q} + 11'(points);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      rd_q    <= LAST_ROW;
      wr_q    <= LAST_ROW;
      count_q <= '0;
      lines_q <= '0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      lines_q <= lines_d;
      score_q <= score_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    lines_d = lines_q;
    score_d = score_q;
    case (state_q)
      IDLE: begin
        if (new_game) score_d = '0;
        if (start) begin
          state_d = SCAN;
          rd_d    = LAST_ROW;
          wr_d    = LAST_ROW;
          count_d = '0;
        end
      end
      SCAN: begin
        if (row_full) begin
          count_d = count_q + 5'd1;
        end else begin
          wr_d = (wr_q == 5'd0) ? 5'd0 : wr_q - 5'd1;
        end
        rd_d = (rd_q == 5'd0) ? 5'd0 : rd_q - 5'd1;
        // The decision on row 0 must include row 0's own contribution to count.
        if (rd_q == 5'd0) state_d = (count_d != 5'd0) ? FILL : DONE;
      end
      FILL: begin
        wr_d = (wr_q == 5'd0) ? 5'd0 : wr_q - 5'd1;
        if (wr_q == 5'd0) state_d = DONE;
      end
      DONE: begin
        lines_d = count_q;
        score_d = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[9:0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    row_raddr = rd_q;
    row_waddr = wr_q;
    row_wdata = row_rdata;
    row_we    = 1'b0;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    case (state_q)
      SCAN: begin
        if (!row_full && (rd_q != wr_q)) row_we = 1'b1;
      end
      FILL: begin
        row_we    = 1'b1;
        row_wdata = '0;
      end
      default: row_we = 1'b0;
    endcase
  end

  assign lines_cleared = lines_q;
  assign score         = score_q;

endmodule
